secuenciador_melodia: RTL

Parametrised melody sequencer: steps through a note/duration table, drives a 16-bit note frequency (Hz) to the tone generator and times each note in clock cycles. It supports start/stop/pause, an articulation gap between notes and an optional loop. It sits between the board control inputs and the square-wave tone generator, which plays `nota` (0 = silence).

---
 rtl/melodia_pkg.sv | 66 ++++++
 rtl/tabla_melodia.sv | 30 +++
 rtl/secuenciador_melodia.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/melodia_pkg.sv
// Shared types and constants for the melody sequencer: state enum, table entry
// layout, default note frequencies and the default 25-entry song.
package melodia_pkg;

   localparam int unsigned NOTA_W_PKG  = 16;
   localparam int unsigned DUR_W_PKG   = 3;
   localparam int unsigned LEN_CANCION = 25;

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      SONANDO  = 2'd1,
      SILENCIO = 2'd2
   } estado_t;

   typedef struct packed {
      logic [NOTA_W_PKG-1:0] nota;
      logic [DUR_W_PKG-1:0]  dur;
   } entrada_t;

   // Default note frequencies in Hz
   localparam logic [NOTA_W_PKG-1:0] DO4  = 16'd261;
   localparam logic [NOTA_W_PKG-1:0] RE4  = 16'd293;
   localparam logic [NOTA_W_PKG-1:0] MI4  = 16'd329;
   localparam logic [NOTA_W_PKG-1:0] FA4  = 16'd349;
   localparam logic [NOTA_W_PKG-1:0] SOL4 = 16'd392;
   localparam logic [NOTA_W_PKG-1:0] LA4  = 16'd440;
   localparam logic [NOTA_W_PKG-1:0] SIB4 = 16'd466;
   localparam logic [NOTA_W_PKG-1:0] DO5  = 16'd523;

   // Default song; out-of-range indices return silence with duration 1
   function automatic entrada_t cancion(input logic [31:0] i);
      entrada_t e;
      e.nota = '0;
      e.dur  = 3'd1;
      case (i)
         32'd0:  e.nota = DO4;
         32'd1:  e.nota = DO4;
         32'd2:  e.nota = RE4;
         32'd3:  e.nota = DO4;
         32'd4:  e.nota = FA4;
         32'd5:  begin e.nota = MI4; e.dur = 3'd2; end
         32'd6:  e.nota = DO4;
         32'd7:  e.nota = DO4;
         32'd8:  e.nota = RE4;
         32'd9:  e.nota = DO4;
         32'd10: e.nota = SOL4;
         32'd11: begin e.nota = FA4; e.dur = 3'd2; end
         32'd12: e.nota = DO4;
         32'd13: e.nota = DO4;
         32'd14: e.nota = DO5;
         32'd15: e.nota = LA4;
         32'd16: e.nota = FA4;
         32'd17: e.nota = MI4;
         32'd18: begin e.nota = RE4; e.dur = 3'd2; end
         32'd19: e.nota = SIB4;
         32'd20: e.nota = SIB4;
         32'd21: e.nota = LA4;
         32'd22: e.nota = FA4;
         32'd23: e.nota = SOL4;
         32'd24: begin e.nota = FA4; e.dur = 3'd4; end
         default: e.dur = 3'd1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/tabla_melodia.sv
// Combinational melody ROM: index -> {nota, dur}. Indices at or beyond LEN read
// as silence with a one-unit duration.
module tabla_melodia
   import melodia_pkg::*;
#(
   parameter int unsigned NOTE_W = 16,
   parameter int unsigned DUR_W  = 3,
   parameter int unsigned LEN    = 25,
   parameter int unsigned IDX_W  = $clog2(LEN)
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [NOTE_W-1:0] nota,
   output logic [DUR_W-1:0]  dur
);

   entrada_t e;

   // Table lookup with out-of-range guard
   always_comb begin
      e.nota = '0;
      e.dur  = 3'd1;
      if (32'(idx) < LEN) begin
         e = cancion(32'(idx));
      end
   end

   assign nota = NOTE_W'(e.nota);
   assign dur  = DUR_W'(e.dur);

endmodule

// File: rtl/secuenciador_melodia.sv
// Melody sequencer: steps through the note table, timing each note in tempo
// units of TICK_DIV cycles followed by GAP_CYC silent cycles.
// Optional feature: define SECUENCIA_BUCLE_EN to let `bucle` wrap playback.
module secuenciador_melodia
   import melodia_pkg::*;
#(
   parameter int unsigned NOTE_W   = 16,
   parameter int unsigned DUR_W    = 3,
   parameter int unsigned LEN      = 25,
   parameter int unsigned IDX_W    = $clog2(LEN),
   parameter int unsigned TICK_DIV = 12_500_000,
   parameter int unsigned GAP_CYC  = 1_250_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inicio,
   input  logic              parar,
   input  logic              pausa,
   input  logic              bucle,
   output logic [NOTE_W-1:0] nota,
   output logic              valido,
   output logic [IDX_W-1:0]  indice,
   output logic              ocupado,
   output logic              fin
);

   // Width guards keep a 1-bit counter when the natural width would be zero
   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   localparam logic [PRE_W-1:0] PRE_ULT = PRE_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_ULT = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(LEN - 1);

   estado_t           estado;
   logic [PRE_W-1:0]  presc;
   logic [DUR_W-1:0]  unidad;
   logic [GAP_W-1:0]  gap;
   logic [DUR_W-1:0]  dur_q;

   logic [IDX_W-1:0]  idx_sig;
   logic [NOTE_W-1:0] rom_nota;
   logic [DUR_W-1:0]  rom_dur;
   logic [DUR_W-1:0]  dur_ef;
   logic              ultimo;
   logic              fin_nota;
   logic              fin_gap;
   logic              avanzar;
   logic              repetir;

   // The ROM always looks one entry ahead: the entry to load when a note starts
   always_comb begin
      idx_sig = indice + IDX_W'(1);
      if (estado == REPOSO || indice == IDX_ULT) begin
         idx_sig = '0;
      end
   end

   tabla_melodia #(
      .NOTE_W (NOTE_W),
      .DUR_W  (DUR_W),
      .LEN    (LEN),
      .IDX_W  (IDX_W)
   ) u_tabla (
      .idx  (idx_sig),
      .nota (rom_nota),
      .dur  (rom_dur)
   );

   assign dur_ef   = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
   assign ultimo   = (indice == IDX_ULT);
   assign fin_nota = (estado == SONANDO) && (presc == PRE_ULT) &&
                     (unidad == dur_q - DUR_W'(1));
   assign fin_gap  = (estado == SILENCIO) && (gap == GAP_ULT);
   // Without a gap the next note follows directly from the end of the current one
   assign avanzar  = (GAP_CYC == 0) ? fin_nota : fin_gap;

`ifdef SECUENCIA_BUCLE_EN
   assign repetir = bucle;
`else
   // bucle is read but has no effect in this build
   assign repetir = bucle & 1'b0;
`endif

   // Sequencer state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n || parar) begin
         estado  <= REPOSO;
         presc   <= '0;
         unidad  <= '0;
         gap     <= '0;
         dur_q   <= '0;
         indice  <= '0;
         nota    <= '0;
         valido  <= 1'b0;
         ocupado <= 1'b0;
         fin     <= 1'b0;
      end else if (!pausa) begin
         fin <= 1'b0;
         if (avanzar) begin
            presc  <= '0;
            unidad <= '0;
            gap    <= '0;
            if (!ultimo || repetir) begin
               estado  <= SONANDO;
               indice  <= idx_sig;
               nota    <= rom_nota;
               valido  <= 1'b1;
               ocupado <= 1'b1;
               dur_q   <= dur_ef;
               fin     <= ultimo;
            end else begin
               // Sequence complete: indice stays on the last entry
               estado  <= REPOSO;
               nota    <= '0;
               valido  <= 1'b0;
               ocupado <= 1'b0;
               fin     <= 1'b1;
            end
         end else begin
            unique case (estado)
               REPOSO: begin
                  if (inicio) begin
                     estado  <= SONANDO;
                     indice  <= idx_sig;
                     nota    <= rom_nota;
                     valido  <= 1'b1;
                     ocupado <= 1'b1;
                     dur_q   <= dur_ef;
                     presc   <= '0;
                     unidad  <= '0;
                  end
               end
               SONANDO: begin
                  if (presc == PRE_ULT) begin
                     presc <= '0;
                     if (unidad == dur_q - DUR_W'(1)) begin
                        unidad <= '0;
                        estado <= SILENCIO;
                        nota   <= '0;
                        valido <= 1'b0;
                        gap    <= '0;
                     end else begin
                        unidad <= unidad + DUR_W'(1);
                     end
                  end else begin
                     presc <= presc + PRE_W'(1);
                  end
               end
               SILENCIO: gap <= gap + GAP_W'(1);
               default:  estado <= REPOSO;
            endcase
         end
      end
   end

endmodule
